// File: rtl/matris_carpici_pkg.sv
// matris_carpici_pkg
//   Shared dimensions, FSM state type and result-width helper for the
//   2x4 by 4x2 streaming matrix multiplier.
package matris_carpici_pkg;

  localparam int ROWS_A    = 2;
  localparam int INNER     = 4;
  localparam int COLS_B    = 2;
  localparam int N_WORDS   = 16;
  localparam int N_RESULTS = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Four 2M-bit products summed need two extra bits.
  function automatic int res_width(input int m);
    return 2 * m + 2;
  endfunction

endpackage

// File: rtl/matris_carpici_mac.sv
// matris_carpici_mac
//   M-bit unsigned multiply-accumulate with clear.
//   sum_o is the combinational value (clr ? 0 : acc) + a*b, which is what
//   the accumulator loads when en_i is high. With clr_i tied high and en_i
//   low the block is a plain multiplier.
// Ports:
//   clk, rst         clock, async active-low reset
//   en_i             load the accumulator with sum_o
//   clr_i            start a fresh sum (ignore the stored accumulator)
//   a_i, b_i         unsigned operands
//   sum_o            running sum including the current product
module matris_carpici_mac
  import matris_carpici_pkg::*;
#(
  parameter int M = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic [M-1:0]             a_i,
  input  logic [M-1:0]             b_i,
  output logic [res_width(M)-1:0]  sum_o
);

  localparam int W = res_width(M);

  logic [W-1:0]   acc_q;
  logic [W-1:0]   acc_d;
  logic [2*M-1:0] prod;

  always_comb begin
    prod  = {{M{1'b0}}, a_i} * {{M{1'b0}}, b_i};
    acc_d = (clr_i ? '0 : acc_q) + {2'b00, prod};
  end

  assign sum_o = acc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matris_carpici.sv
// matris_carpici
//   Streaming unsigned matrix multiplier C(2x2) = A(2x4) x B(4x2).
//   Loads 16 valid-qualified words (A row-major, then B row-major),
//   computes the four C entries, then emits them row-major as a
//   contiguous 4-cycle valid burst. No backpressure.
//   Build option MATRIS_CARPICI_PARALLEL_EN: four multipliers plus an adder
//   tree, one C entry per cycle (CALC = 4 cycles). Default: one serial MAC,
//   one product per cycle (CALC = 16 cycles).
// Ports:
//   clk, rst         clock, async active-low reset
//   matris_veri      operand word, matris_gecerli its valid (LOAD only)
//   carpim_veri      result word (registered), carpim_gecerli its valid
//
// state | meaning
// LOAD  | accept operand words into slot cnt, 0..15
// CALC  | form products and sums, write result registers
// OUT   | cnt 0..3 present R[cnt]; cnt 4 drops valid and returns to LOAD
module matris_carpici
  import matris_carpici_pkg::*;
#(
  parameter int M = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [M-1:0]             matris_veri,
  input  logic                     matris_gecerli,
  output logic [res_width(M)-1:0]  carpim_veri,
  output logic                     carpim_gecerli
);

  localparam int W = res_width(M);
`ifdef MATRIS_CARPICI_PARALLEL_EN
  localparam logic [4:0] CALC_LAST = 5'(N_RESULTS - 1);
`else
  localparam logic [4:0] CALC_LAST = 5'(N_RESULTS * INNER - 1);
`endif

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [M-1:0] word_q [N_WORDS];
  logic [W-1:0] res_q  [N_RESULTS];
  logic [W-1:0] carpim_veri_q;
  logic         carpim_gecerli_q;

  logic [W-1:0] sum;
  logic [1:0]   res_idx;
  logic         res_we;
  logic         r, c;

  assign r = res_idx[1];
  assign c = res_idx[0];

`ifdef MATRIS_CARPICI_PARALLEL_EN
  logic [W-1:0] prod [INNER];

  assign res_idx = cnt_q[1:0];
  assign res_we  = (state_q == CALC);

  for (genvar g = 0; g < INNER; g++) begin : g_mac
    localparam logic [1:0] KG = 2'(g);
    matris_carpici_mac #(.M(M)) u_mac (
      .clk   (clk),
      .rst   (rst),
      .en_i  (1'b0),
      .clr_i (1'b1),
      .a_i   (word_q[{1'b0, r, KG}]),
      .b_i   (word_q[{1'b1, KG, c}]),
      .sum_o (prod[g])
    );
  end

  assign sum = (prod[0] + prod[1]) + (prod[2] + prod[3]);
`else
  logic [1:0] k;

  // cnt = 4*i + k: element i, inner term k.
  assign k       = cnt_q[1:0];
  assign res_idx = cnt_q[3:2];
  assign res_we  = (state_q == CALC) && (k == 2'd3);

  matris_carpici_mac #(.M(M)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == CALC),
    .clr_i (k == 2'd0),
    .a_i   (word_q[{1'b0, r, k}]),
    .b_i   (word_q[{1'b1, k, c}]),
    .sum_o (sum)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD: begin
        if (matris_gecerli) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(N_WORDS - 1)) begin
            state_d = CALC;
            cnt_d   = '0;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CALC_LAST) begin
          state_d = OUT;
          cnt_d   = '0;
        end
      end
      OUT: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(N_RESULTS)) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_WORDS; i++) word_q[i] <= '0;
      for (int i = 0; i < N_RESULTS; i++) res_q[i] <= '0;
      carpim_veri_q    <= '0;
      carpim_gecerli_q <= 1'b0;
    end else begin
      if ((state_q == LOAD) && matris_gecerli) begin
        word_q[cnt_q[3:0]] <= matris_veri;
      end
      if (res_we) begin
        res_q[res_idx] <= sum;
      end
      if (state_q == OUT) begin
        if (cnt_q < 5'(N_RESULTS)) begin
          carpim_veri_q    <= res_q[cnt_q[1:0]];
          carpim_gecerli_q <= 1'b1;
        end else begin
          carpim_gecerli_q <= 1'b0;
        end
      end
    end
  end

  assign carpim_veri    = carpim_veri_q;
  assign carpim_gecerli = carpim_gecerli_q;

endmodule

// File: tb/tb_matris_carpici.sv
module tb_matris_carpici;

  localparam int M = 16;
  localparam int W = 2 * M + 2;
`ifdef MATRIS_CARPICI_PARALLEL_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 17;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [M-1:0] matris_veri = '0;
  logic         matris_gecerli = 1'b0;
  logic [W-1:0] carpim_veri;
  logic         carpim_gecerli;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  exp_q [$];
  logic [M-1:0]  cur_w [16];
  logic [W-1:0]  const_exp [4];

  matris_carpici #(.M(M)) dut (
    .clk            (clk),
    .rst            (rst),
    .matris_veri    (matris_veri),
    .matris_gecerli (matris_gecerli),
    .carpim_veri    (carpim_veri),
    .carpim_gecerli (carpim_gecerli)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every valid output pops one expectation.
  always @(negedge clk) begin
    if (rst && carpim_gecerli) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0h, expected no output", carpim_veri);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (carpim_veri !== e) begin
          errors++;
          $display("FAIL result: got %0h, expected %0h", carpim_veri, e);
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_basic();
    int a [8] = '{2, 3, 4, 0, 1, 1, 9, 8};
    int b [8] = '{2, 0, 9, 3, 1, 4, 6, 1};
    for (int i = 0; i < 8; i++) begin
      cur_w[i]     = M'(a[i]);
      cur_w[8 + i] = M'(b[i]);
    end
    const_exp[0] = 35; const_exp[1] = 25; const_exp[2] = 68; const_exp[3] = 47;
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) cur_w[i] = M'($urandom);
  endtask

  // Streams cur_w, pushes expectations, follows the output burst.
  // abort_at > 0: async reset that many edges after word 15 was stored,
  // only the first n_keep results are expected.
  task automatic run(input logic [15:0] gap_mask, input bit garbage, input bit use_const,
                     input int abort_at, input int n_keep);
    int  cycles, first, nval;
    bit  done;
    for (int i = 0; i < n_keep; i++) begin
      longint unsigned s;
      int row, col;
      row = i / 2;
      col = i % 2;
      s = 0;
      for (int k = 0; k < 4; k++)
        s += longint'(cur_w[4 * row + k]) * longint'(cur_w[8 + 2 * k + col]);
      exp_q.push_back(use_const ? const_exp[i] : W'(s));
    end
    for (int i = 0; i < 16; i++) begin
      matris_veri    = cur_w[i];
      matris_gecerli = 1'b1;
      @(negedge clk);
      if (gap_mask[i]) begin
        matris_gecerli = 1'b0;
        matris_veri    = M'($urandom);
        @(negedge clk);
      end
    end
    matris_gecerli = 1'b0;
    cycles = 0; first = 0; nval = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (cycles == abort_at) begin
        #3 rst = 1'b0;
        #1;
        check("abort_valid_low", carpim_gecerli, 0);
        check("abort_data_zero", carpim_veri, 0);
        matris_gecerli = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        done = 1'b1;
      end else begin
        if (carpim_gecerli) begin
          nval++;
          if (first == 0) first = cycles;
        end else if (nval > 0) begin
          done = 1'b1;
        end
        if (cycles > 100) begin
          errors++;
          checks++;
          $display("FAIL timeout: got %0d valid cycles after %0d edges, expected 4", nval, cycles);
          done = 1'b1;
        end
        if (!done && garbage) begin
          matris_gecerli = 1'b1;
          matris_veri    = M'($urandom);
        end else begin
          matris_gecerli = 1'b0;
        end
      end
    end
    matris_gecerli = 1'b0;
    if (abort_at == 0) begin
      check("first_valid_latency", first, LAT);
      check("valid_burst_len", nval, 4);
      check("data_held_after_burst", carpim_veri, exp_last());
    end
  endtask

  logic [W-1:0] last_seen;
  always @(negedge clk) if (rst && carpim_gecerli) last_seen <= carpim_veri;
  function automatic logic [W-1:0] exp_last();
    return last_seen;
  endfunction

  initial begin
    rst = 1'b0;
    #12;
    check("reset_valid", carpim_gecerli, 0);
    check("reset_data", carpim_veri, 0);
    @(negedge clk);
    rst = 1'b1;

    load_basic();
    run(16'h0000, 1'b0, 1'b1, 0, 4);
    // Back-to-back, bubbles after A01 and B20.
    run(16'h1002, 1'b0, 1'b1, 0, 4);

    for (int i = 0; i < 16; i++) cur_w[i] = 16'hFFFF;
    for (int i = 0; i < 4; i++) const_exp[i] = 34'h3_FFF8_0004;
    run(16'h0000, 1'b0, 1'b1, 0, 4);

    // Garbage during CALC/OUT, then a clean run right after.
    load_random();
    run(16'h0000, 1'b1, 1'b0, 0, 4);
    load_random();
    run(16'h0000, 1'b0, 1'b0, 0, 4);

    // Abort during CALC, then during the output burst.
    load_random();
    run(16'h0000, 1'b0, 1'b0, 2, 0);
    repeat (30) @(negedge clk);
    load_random();
    run(16'h0000, 1'b0, 1'b0, 0, 4);
    load_random();
    run(16'h0000, 1'b0, 1'b0, LAT + 2, 3);
    repeat (30) @(negedge clk);

    for (int n = 0; n < 8; n++) begin
      load_random();
      run(16'(($urandom % 2) ? $urandom : 0) & 16'h7FFF, 1'b0, 1'b0, 0, 4);
      pulse_reset();
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matris_carpici.md
Name: matris_carpici

Overview:
- Streaming unsigned integer matrix multiplier: C(2x2) = A(2x4) x B(4x2).
- Operands arrive one word per cycle over a valid-qualified input stream: 8 words of A, then 8 words of B, each row-major.
- The four C entries leave in row-major order over a valid-qualified output stream.
- Standalone compute block between a word-serial producer and consumer; no backpressure.

Parameters:
- M, 16, bit width of each unsigned A/B element. Output width is 2*M+2.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low; clears all state.
- matris_veri  input  M  operand word (A00..A13, then B00..B31, row-major).
- matris_gecerli  input  1  operand word valid; sampled on rising clk.
- carpim_veri  output  2*M+2  result word C00, C01, C10, C11 in order.
- carpim_gecerli  output  1  result valid.

Behaviour:
- Reset (rst=0, asynchronous): state=LOAD, word counter=0, accumulators=0, carpim_veri=0, carpim_gecerli=0.
- States: LOAD -> CALC -> OUT -> LOAD.
- LOAD
  - Each edge with matris_gecerli=1 stores the word at index cnt (0..15) and increments cnt. Words 0-7 are A[r][k] (index 4r+k); words 8-15 are B[k][c] (index 8+2k+c).
  - matris_gecerli=0 cycles are gaps: nothing is stored and cnt holds.
  - The edge that stores word 15 moves the block to CALC.
- CALC (default serial)
  - One multiplier and one accumulator; one product per cycle.
  - Order: C00 terms k=0..3, then C01, C10, C11.
  - After the fourth term of an element, its sum is stored in result register R[i]. 16 cycles total, then OUT.
- OUT
  - carpim_gecerli=1 for exactly 4 consecutive cycles, carrying R[0], R[1], R[2], R[3].
  - Then carpim_gecerli=0, carpim_veri holds its last value, cnt=0, state=LOAD.
- Latency: first carpim_gecerli=1 is visible after the 17th rising edge following the edge that stored word 15. Valid deasserts after the 21st.
- Arithmetic
  - Unsigned throughout. Products are 2M bits; sums are 2M+2 bits, so there is no overflow (max 4*(2^M-1)^2).
- Input handling outside LOAD: matris_gecerli is ignored in CALC and OUT, and those words are dropped.
- Reset mid-operation: any state aborts immediately to reset values. Partial operands are discarded.
- Outputs are registered.
- Back-to-back operations: a new A word may be presented the cycle after carpim_gecerli falls.

Optional Feature:
- MATRIS_CARPICI_PARALLEL_EN defined
  - CALC instantiates four multipliers and an adder tree, computing one full C element per cycle. CALC lasts 4 cycles.
  - First valid output appears after the 5th edge following the edge that stored word 15.
- Undefined: serial single-MAC datapath described above.
- Output ordering, widths and the 4-cycle contiguous valid burst are identical in both builds.

Decomposition:
- Package matris_carpici_pkg:
  - Dimension constants ROWS_A=2, INNER=4, COLS_B=2, N_WORDS=16, N_RESULTS=4.
  - State enum {LOAD, CALC, OUT}.
  - Result-width helper (2*M+2).
- Sub-module matris_carpici_mac: M-bit unsigned multiply-accumulate with clear. The parallel build uses four instances or a summing wrapper.

Test Plan:
- Basic: A=[2 3 4 0; 1 1 9 8], B=[2 0; 9 3; 1 4; 6 1], streamed over 16 contiguous valid cycles -> outputs 35, 25, 68, 47 on 4 consecutive valid cycles, then carpim_gecerli=0.
- Max values: all 16 words 0xFFFF -> all four outputs 0x3_FFF8_0004 (full 34-bit width, no truncation), then valid low.
- Random: 8 back-to-back runs with random 16-bit operands, pulsing rst low one cycle between runs -> each C entry equals the reference dot product; exactly 4 valid cycles per run.
- Input gaps: insert matris_gecerli=0 bubbles between words (e.g. after A01 and B20) -> results identical to the contiguous run.
- Reset mid-operation: assert rst=0 asynchronously during CALC -> carpim_gecerli=0 immediately, no outputs. A fresh run then yields correct results.
- Ignored input: drive matris_gecerli=1 with garbage during CALC/OUT -> results unaffected. The next operation starts loading only after return to LOAD.
